// File: rtl/axi_r_beat_issuer.sv
// axi_r_beat_issuer
// AXI read-data egress stage behind the read-channel clock-crossing FIFO.
// Pops R words from the FIFO into a 2-entry skid buffer and presents them on a
// standard AXI R valid/ready interface. Burst lengths from accepted AR requests
// are queued so every RLAST can be checked against the expected beat count; any
// disagreement sets a sticky error flag.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   fifo_not_empty/rd_en/r_data  FIFO read port; word = {RID, RDATA, RRESP, RLAST}
//   ar_push, ar_len, ar_full  burst-length queue write side (ar_len = beats-1)
//   RID/RDATA/RRESP/RLAST/RVALID/RREADY  AXI R channel toward the master
//   err_last, err_clr         sticky RLAST protocol error and its clear

module axi_r_beat_issuer #(
  parameter int unsigned DW       = 32,
  parameter int unsigned IDW      = 8,
  parameter int unsigned LQ_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                fifo_not_empty,
  output logic                fifo_rd_en,
  input  logic [DW+IDW+2:0]   fifo_r_data,
  input  logic                ar_push,
  input  logic [3:0]          ar_len,
  output logic                ar_full,
  output logic [IDW-1:0]      RID,
  output logic [DW-1:0]       RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY,
  output logic                err_last,
  input  logic                err_clr
);

  localparam int unsigned WW = DW + IDW + 3;
  localparam int unsigned PW = $clog2(LQ_DEPTH) + 1;  // pointer width incl. wrap bit
  localparam int unsigned AW = PW - 1;

  // Skid buffer state
  logic [1:0]    cnt_q, cnt_d;
  logic [WW-1:0] head_q, head_d;
  logic [WW-1:0] tail_q, tail_d;

  // Burst-length queue state
  logic [3:0]    lq_mem [LQ_DEPTH];
  logic [PW-1:0] lq_wr_q, lq_rd_q;
  logic [PW-1:0] lq_cnt_q, lq_cnt_d;
  logic [3:0]    beat_q, beat_d;
  logic          err_q, err_d;

  logic push, hs, lq_push, lq_pop, exp_last, end_burst, err_set;
  logic [3:0] head_len;

  // Gated by rstn so the pop request drops the instant reset asserts.
  assign fifo_rd_en = rstn && fifo_not_empty && (cnt_q < 2'd2);
  assign push       = fifo_rd_en;
  assign RVALID     = (cnt_q != 2'd0);
  assign hs         = RVALID && RREADY;

  assign RID   = head_q[WW-1 -: IDW];
  assign RDATA = head_q[DW+2:3];
  assign RRESP = head_q[2:1];
  assign RLAST = head_q[0];

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({push, hs})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = fifo_r_data;
        else               tail_d = fifo_r_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = fifo_r_data;
        end else begin
          head_d = tail_q;
          tail_d = fifo_r_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Burst tracking
  assign ar_full   = (lq_cnt_q == PW'(LQ_DEPTH));
  assign lq_push   = ar_push && !ar_full;
  assign head_len  = lq_mem[lq_rd_q[AW-1:0]];
  assign exp_last  = (lq_cnt_q != '0) && (beat_q == head_len);
  assign end_burst = RLAST || exp_last;
  // An RLAST with nothing queued still closes the burst but has nothing to pop.
  assign lq_pop    = hs && end_burst && (lq_cnt_q != '0);
  assign err_set   = hs && ((RLAST != exp_last) || (lq_cnt_q == '0));

  always_comb begin
    lq_cnt_d = lq_cnt_q;
    if (lq_push && !lq_pop)      lq_cnt_d = lq_cnt_q + PW'(1);
    else if (!lq_push && lq_pop) lq_cnt_d = lq_cnt_q - PW'(1);

    beat_d = beat_q;
    if (hs) beat_d = end_burst ? 4'd0 : beat_q + 4'd1;

    // Set has priority over clear.
    err_d = err_q;
    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(LQ_DEPTH); i++) lq_mem[i] <= '0;
      lq_wr_q  <= '0;
      lq_rd_q  <= '0;
      lq_cnt_q <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (lq_push) begin
        lq_mem[lq_wr_q[AW-1:0]] <= ar_len;
        lq_wr_q <= lq_wr_q + PW'(1);
      end
      if (lq_pop) lq_rd_q <= lq_rd_q + PW'(1);
      lq_cnt_q <= lq_cnt_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
    end
  end

  assign err_last = err_q;

endmodule

// File: tb/tb_axi_r_beat_issuer.sv
// Directed bench for axi_r_beat_issuer. A queue models the upstream FIFO; each
// popped word is pushed onto a scoreboard and checked when its R handshake occurs.

module tb_axi_r_beat_issuer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        fifo_not_empty;
  logic        fifo_rd_en;
  logic [42:0] fifo_r_data;
  logic        ar_push;
  logic [3:0]  ar_len;
  logic        ar_full;
  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        err_last;
  logic        err_clr;

  logic [42:0] fifo_q [$];
  logic [42:0] sb_q   [$];
  int n_cmp  = 0;
  int n_fail = 0;
  int n_pop  = 0;
  int n_hs   = 0;

  axi_r_beat_issuer #(.DW(32), .IDW(8), .LQ_DEPTH(4)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .fifo_not_empty (fifo_not_empty),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_r_data    (fifo_r_data),
    .ar_push        (ar_push),
    .ar_len         (ar_len),
    .ar_full        (ar_full),
    .RID            (RID),
    .RDATA          (RDATA),
    .RRESP          (RRESP),
    .RLAST          (RLAST),
    .RVALID         (RVALID),
    .RREADY         (RREADY),
    .err_last       (err_last),
    .err_clr        (err_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [42:0] mk(input logic [7:0] id, input logic [31:0] d,
                                     input logic [1:0] resp, input logic last);
    return {id, d, resp, last};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_not_empty = (fifo_q.size() != 0);
    fifo_r_data    = fifo_not_empty ? fifo_q[0] : '0;
    #1;
  endtask

  // One clock: score any handshake, model the FIFO pop, then release pulses.
  task automatic step();
    logic [42:0] exp;
    drive_fifo();
    if (RVALID && RREADY) begin
      n_hs++;
      if (sb_q.size() == 0) begin
        check("unexpected_beat", 64'd1, 64'd0);
      end else begin
        exp = sb_q.pop_front();
        check("r_beat", 64'({RID, RDATA, RRESP, RLAST}), 64'(exp));
      end
    end
    if (fifo_rd_en && fifo_not_empty) begin
      n_pop++;
      sb_q.push_back(fifo_q.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    ar_push = 1'b0;
    err_clr = 1'b0;
    drive_fifo();
  endtask

  task automatic drain();
    int budget = 40;
    while ((sb_q.size() != 0 || fifo_q.size() != 0) && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int hs0;
    rstn = 1'b0; ar_push = 1'b0; ar_len = '0; RREADY = 1'b0; err_clr = 1'b0;
    fifo_not_empty = 1'b1; fifo_r_data = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_rvalid", 64'(RVALID), 64'd0);
    check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    check("rst_ar_full", 64'(ar_full), 64'd0);
    check("rst_err", 64'(err_last), 64'd0);
    check("rst_fields", 64'({RID, RDATA, RRESP, RLAST}), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    drive_fifo();

    // Single-beat read
    RREADY = 1'b1; ar_len = 4'd0; ar_push = 1'b1;
    step();
    fifo_q.push_back(mk(8'h12, 32'hDEADBEEF, 2'd0, 1'b1));
    step();
    check("single_rvalid", 64'(RVALID), 64'd1);
    check("single_fields", 64'({RID, RDATA, RRESP, RLAST}),
          64'(mk(8'h12, 32'hDEADBEEF, 2'd0, 1'b1)));
    step();
    check("single_err", 64'(err_last), 64'd0);
    check("single_done", 64'(RVALID), 64'd0);

    // Backpressure
    ar_len = 4'd3; ar_push = 1'b1; RREADY = 1'b0;
    step();
    for (int i = 0; i < 4; i++)
      fifo_q.push_back(mk(8'h40 + 8'(i), 32'hA000_0000 + 32'(i), 2'(i), (i == 3)));
    n_pop = 0;
    repeat (4) step();
    check("bp_pops", 64'(n_pop), 64'd2);
    check("bp_rd_en", 64'(fifo_rd_en), 64'd0);
    check("bp_rvalid", 64'(RVALID), 64'd1);
    check("bp_stable", 64'(RDATA), 64'h0000_0000_A000_0000);
    RREADY = 1'b1; n_hs = 0;
    repeat (4) step();
    check("bp_consecutive", 64'(n_hs), 64'd4);
    check("bp_all_out", 64'(sb_q.size() + fifo_q.size()), 64'd0);
    check("bp_err", 64'(err_last), 64'd0);

    // Unexpected beat with empty length queue
    fifo_q.push_back(mk(8'h33, 32'h1234_5678, 2'd2, 1'b1));
    drain();
    check("unexp_err", 64'(err_last), 64'd1);
    err_clr = 1'b1;
    step();
    check("unexp_clr", 64'(err_last), 64'd0);

    // Early RLAST on beat 2 of a 4-beat burst
    ar_len = 4'd3; ar_push = 1'b1;
    step();
    for (int i = 0; i < 4; i++)
      fifo_q.push_back(mk(8'h50, 32'hB000_0000 + 32'(i), 2'd0, (i == 2)));
    drain();
    check("early_err", 64'(err_last), 64'd1);
    step();
    check("early_sticky", 64'(err_last), 64'd1);
    err_clr = 1'b1;
    step();
    check("early_clr", 64'(err_last), 64'd0);
    fifo_q.push_back(mk(8'h51, 32'hC0DE_0001, 2'd0, 1'b1));
    step();
    err_clr = 1'b1;
    step();
    check("set_wins", 64'(err_last), 64'd1);
    err_clr = 1'b1;
    step();
    check("set_wins_clr", 64'(err_last), 64'd0);

    // Length queue full
    ar_len = 4'd0;
    repeat (4) begin
      ar_push = 1'b1;
      step();
    end
    check("full_set", 64'(ar_full), 64'd1);
    ar_push = 1'b1;
    step();
    check("full_hold", 64'(ar_full), 64'd1);
    fifo_q.push_back(mk(8'h60, 32'h6000_0000, 2'd0, 1'b1));
    step();
    step();
    check("full_drop", 64'(ar_full), 64'd0);
    for (int i = 1; i < 4; i++)
      fifo_q.push_back(mk(8'h60 + 8'(i), 32'h6000_0000 + 32'(i), 2'd0, 1'b1));
    drain();
    check("full_bursts_err", 64'(err_last), 64'd0);
    fifo_q.push_back(mk(8'h6F, 32'h6000_00FF, 2'd0, 1'b1));
    drain();
    check("fifth_ignored", 64'(err_last), 64'd1);
    err_clr = 1'b1;
    step();

    // Reset mid-burst
    ar_len = 4'd3; ar_push = 1'b1;
    step();
    ar_len = 4'd0;
    repeat (3) begin
      ar_push = 1'b1;
      step();
    end
    check("pre_rst_full", 64'(ar_full), 64'd1);
    fifo_q.push_back(mk(8'h70, 32'h7000_0000, 2'd0, 1'b0));
    fifo_q.push_back(mk(8'h70, 32'h7000_0001, 2'd0, 1'b0));
    drain();
    RREADY = 1'b0;
    for (int i = 2; i < 5; i++)
      fifo_q.push_back(mk(8'h70, 32'h7000_0000 + 32'(i), 2'd0, 1'b0));
    repeat (2) step();
    check("pre_rst_rvalid", 64'(RVALID), 64'd1);
    rstn = 1'b0;
    #1;
    check("rst_mid_rvalid", 64'(RVALID), 64'd0);
    check("rst_mid_rd_en", 64'(fifo_rd_en), 64'd0);
    check("rst_mid_ar_full", 64'(ar_full), 64'd0);
    fifo_q.delete();
    sb_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    drive_fifo();
    RREADY = 1'b1; ar_len = 4'd0; ar_push = 1'b1;
    step();
    hs0 = n_hs;
    fifo_q.push_back(mk(8'h80, 32'h8000_0000, 2'd1, 1'b1));
    drain();
    check("post_rst_beat", 64'(n_hs - hs0), 64'd1);
    check("post_rst_err", 64'(err_last), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_r_beat_issuer.md
# axi_r_beat_issuer

Single-clock AXI read-data egress stage that sits directly downstream of the read-channel clock-crossing FIFO. It pops 43-bit R-channel words out of the FIFO read port, holds them in a 2-entry skid buffer and drives a standard AXI R valid/ready interface toward the master. It also tracks outstanding burst lengths from AR handshakes and flags any RLAST that disagrees with the expected beat count.

## Interface
Parameters:
- DW, 32, RDATA width.
- IDW, 8, RID width. DW+IDW+3 must equal 43.
- LQ_DEPTH, 4, burst-length queue depth (power of 2).

Ports:
- clk  in  1  clock; the FIFO read-side clock domain.
- rstn  in  1  asynchronous, active-low reset.
- fifo_not_empty  in  1  FIFO has at least one word.
- fifo_rd_en  out  1  pop request to the FIFO.
- fifo_r_data  in  43  FIFO word, valid only while fifo_rd_en && fifo_not_empty. Layout: [42:35] RID, [34:3] RDATA, [2:1] RRESP, [0] RLAST.
- ar_push  in  1  AR handshake accepted by the master side; enqueue ar_len.
- ar_len  in  4  ARLEN of the accepted request (beats-1).
- ar_full  out  1  length queue full; the upstream AR path must stall.
- RID  out  8
- RDATA  out  32
- RRESP  out  2
- RLAST  out  1
- RVALID  out  1
- RREADY  in  1
- err_last  out  1  sticky protocol error.
- err_clr  in  1  clears err_last.

## Operation
- Skid buffer: 2 entries (head, tail), 2-bit occupancy count `cnt`.
  - RVALID = (cnt != 0). R outputs come from the head entry.
- FIFO pop:
  - fifo_rd_en = fifo_not_empty && (cnt < 2). Derived from the registered cnt only; no combinational path from RREADY.
  - fifo_r_data is captured into the buffer on the same edge as the pop.
- Buffer update on each edge:
  - Push only: cnt+1. Data goes to head if cnt was 0, else to tail.
  - Handshake only (RVALID && RREADY): cnt-1, and tail shifts to head.
  - Both together: cnt unchanged. If cnt was 1, the new word goes to head; if cnt was 2, tail moves to head and the new word goes to tail.
- R fields pass through unmodified. RLAST is never rewritten.
- Length queue: LQ_DEPTH entries with 3-bit wrap pointers.
  - ar_full = (lq_cnt == LQ_DEPTH).
  - ar_push while full is ignored and leaves no state change.
  - A simultaneous push and pop leaves lq_cnt unchanged.
- Beat counter `beat` (4 bits) advances on each R handshake. Let exp_last = (lq_cnt != 0) && (beat == lq_head_len).
  - If RLAST != exp_last, or a handshake occurs with lq_cnt == 0: set err_last.
  - If RLAST == 1 or exp_last == 1: pop the queue and set beat to 0. Otherwise beat+1.
- err_last:
  - Set on error, cleared by err_clr.
  - Set wins when both occur in the same cycle.

## Timing
- Reset values: fifo_rd_en=0, RVALID=0, RID/RDATA/RRESP/RLAST=0, ar_full=0, err_last=0, cnt=0, lq_cnt=0, beat=0.
- Assertion of rstn takes effect immediately (asynchronous). This clears an in-flight burst and discards buffered beats.
- Latency: a word popped at edge N is presented with RVALID=1 in the cycle after N.
- Throughput: 1 beat/cycle sustained while the FIFO is non-empty and RREADY=1.
- AXI rule: once RVALID=1, the R fields and RVALID hold stable until RREADY=1.
- ar_full reflects registered lq_cnt and updates the cycle after a push or pop.

## Test plan
- Single-beat read: ar_push with ar_len=0, then FIFO word RID=0x12, RDATA=0xDEADBEEF, RRESP=0, RLAST=1, with RREADY=1. Required: RVALID=1 one cycle after the pop with fields exact, err_last=0, and lq_cnt back to 0.
- Backpressure: 4 words in the FIFO with RREADY=0. Required: exactly 2 pops, then fifo_rd_en=0 and RVALID held with stable data. Raise RREADY: all 4 beats delivered in order on consecutive cycles.
- Early RLAST: ar_len=3, beats 0..3 sent with RLAST=1 on beat 2. Required: err_last=1 after that handshake and it stays set. Pulse err_clr: err_last=0. Pulse err_clr in the same cycle as a new error: err_last stays 1.
- Queue full: 4 ar_push pulses. Required: ar_full=1, and a 5th push is ignored. Complete one len-0 burst: ar_full drops to 0 the next cycle.
- Unexpected beat: RLAST=1 word with lq_cnt=0. Required: beat delivered and err_last=1.
- Reset mid-burst: rstn low while cnt=2 and beat=2. Required: RVALID=0, fifo_rd_en=0 and ar_full=0 immediately. After release, a fresh len-0 burst completes with no error.
